cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/halt/step sequencer for the single-cycle CPU. Gates architectural commit (PC, register file, DMEM
//  writes) through CPU_en, loads a start PC, stops on breakpoint or exception, and counts cycles and
//  retired instructions. Sits between the debug/host command port and the CPU datapath.
// PARAMETERS
//  PC_W   32  width of PC, breakpoint address and CMD_arg
//  CNT_W  32  width of cycle and retired-instruction counters (saturating)
// PORTS
//  SYS_clk        in   1      system clock; all state updates on rising edge
//  SYS_reset      in   1      asynchronous, active-low reset (0 = reset)
//  CMD_valid      in   1      host command valid
//  CMD_ready      out  1      controller can accept a command this cycle
//  CMD_op         in   3      0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SETBP, 5 CLRBP, 6 LOADPC, 7 reserved (= NOP)
//  CMD_arg        in   PC_W   breakpoint address (SETBP) or start PC (LOADPC)
//  CPU_pc         in   PC_W   current CPU PC
//  CPU_exception  in   1      CPU exception flag for the instruction at CPU_pc
//  CPU_en         out  1      commit enable; CPU updates PC/regs/DMEM only when 1
//  CPU_pc_load    out  1      one-cycle pulse: CPU loads PC <= CPU_pc_val
//  CPU_pc_val     out  PC_W   PC value to load
//  CTRL_state     out  3      0 IDLE, 1 RUN, 2 STEP, 3 HALT, 4 EXC
//  CTRL_bp_hit    out  1      sticky: stopped on breakpoint
//  CTRL_exc       out  1      sticky: stopped on exception
//  CTRL_cycles    out  CNT_W  count of cycles with CPU_en = 1
//  CTRL_retired   out  CNT_W  count of committed non-excepting instructions
// BEHAVIOUR
//  Reset (SYS_reset = 0, async): state IDLE; CPU_pc_load 0; CPU_pc_val 0; bp_valid 0; bp_addr 0; skip 0;
//   CTRL_bp_hit 0; CTRL_exc 0; both counters 0; CMD_ready 0 while in reset.
//  Handshake: command accepted on rising edge when CMD_valid & CMD_ready. CMD_ready = 1 in every state except
//   STEP. Decoding uses the registered state; effects visible the next cycle.
//  bp_match = bp_valid & (CPU_pc == bp_addr) & !skip  (combinational).
//  CPU_en = (state == RUN & !bp_match) | (state == STEP)  (combinational, zero latency).
//  Transitions:
//   IDLE/HALT: RUN -> RUN; skip <= 1; CTRL_bp_hit <= 0. STEP -> STEP; CTRL_bp_hit <= 0.
//   RUN: bp_match -> HALT; CTRL_bp_hit <= 1 (CPU_en already 0). HALT cmd -> HALT.
//     bp_match + HALT cmd in the same cycle -> HALT with CTRL_bp_hit = 1.
//     CPU_en & CPU_exception -> EXC; CTRL_exc <= 1. Exception takes priority over a HALT cmd.
//     skip clears after the first cycle with CPU_en = 1.
//   STEP: lasts exactly 1 cycle with CPU_en = 1; breakpoint is ignored. Then -> HALT, or -> EXC if CPU_exception.
//   EXC: CPU_en = 0. RUN/STEP/HALT are accepted but have no effect. LOADPC -> HALT; CTRL_exc <= 0.
//  LOADPC: honoured in IDLE/HALT/EXC only; ignored (still accepted) in RUN.
//   Next cycle: CPU_pc_load = 1 for one cycle; CPU_pc_val = CMD_arg (held until the next LOADPC).
//   Both counters clear to 0. IDLE stays IDLE; EXC -> HALT.
//  SETBP: bp_addr <= CMD_arg; bp_valid <= 1. CLRBP: bp_valid <= 0. Both honoured in any state except STEP.
//  Counters: CTRL_cycles += 1 when CPU_en. CTRL_retired += 1 when CPU_en & !CPU_exception.
//   Both saturate at all-ones (no wrap).
//  An exception raised while CPU_en = 1 still sees CPU_en = 1 that cycle, so the CPU captures EPC.
//   Writes remain suppressed by the CPU.
//  Reset asserted mid-RUN/STEP: CPU_en drops to 0 asynchronously; all state returns to reset values.
// TESTING
//  T1 reset -> LOADPC 0x40 -> RUN for 10 cycles, no exception:
//     CPU_pc_load 1 for 1 cycle with CPU_pc_val 0x40; CTRL_cycles = CTRL_retired = 10; CTRL_state 1.
//  T2 SETBP 0x4C, RUN from 0x40: CPU_en 1 for 3 cycles; at CPU_pc 0x4C, CPU_en 0 in the same cycle;
//     next cycle state HALT, CTRL_bp_hit 1, CTRL_retired 3.
//     RUN again -> 0x4C executes (skip); CTRL_bp_hit 0.
//  T3 from HALT, STEP x3: each STEP gives exactly one CPU_en cycle; CMD_ready 0 during STEP;
//     CTRL_retired += 3; breakpoint at the stepped PC does not stop it.
//  T4 RUN, assert CPU_exception for 1 cycle:
//     CPU_en 1 that cycle; CTRL_cycles += 1; CTRL_retired unchanged; state EXC; CTRL_exc 1.
//     RUN ignored. LOADPC 0x0 -> HALT; CTRL_exc 0; counters 0.
//  T5 RUN; bp_match and HALT cmd in the same cycle -> HALT, CTRL_bp_hit 1.
//     Drive SYS_reset = 0 mid-RUN -> CPU_en 0 immediately; CTRL_state 0; counters 0.
//  T6 preload counters near all-ones (CNT_W = 4 build), RUN 20 cycles: both counters stick at 4'hF.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Host command port for the CPU run controller.
// Valid/ready handshake carrying an opcode and an argument.
interface cpu_run_ctrl_if #(
  parameter int PC_W = 32
);
  logic            CMD_valid;
  logic            CMD_ready;
  logic [2:0]      CMD_op;
  logic [PC_W-1:0] CMD_arg;

  modport master (
    output CMD_valid,
    output CMD_op,
    output CMD_arg,
    input  CMD_ready
  );

  modport slave (
    input  CMD_valid,
    input  CMD_op,
    input  CMD_arg,
    output CMD_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle CPU.
// Gates commit, loads start PC, stops on breakpoint/exception, counts.
module cpu_run_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  cpu_run_ctrl_if.slave    cmd,
  input  logic [PC_W-1:0]  CPU_pc,
  input  logic             CPU_exception,
  output logic             CPU_en,
  output logic             CPU_pc_load,
  output logic [PC_W-1:0]  CPU_pc_val,
  output logic [2:0]       CTRL_state,
  output logic             CTRL_bp_hit,
  output logic             CTRL_exc,
  output logic [CNT_W-1:0] CTRL_cycles,
  output logic [CNT_W-1:0] CTRL_retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_HALT = 3'd3,
    S_EXC  = 3'd4
  } state_e;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SETBP  = 3'd4;
  localparam logic [2:0] OP_CLRBP  = 3'd5;
  localparam logic [2:0] OP_LOADPC = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             bp_valid_q, bp_valid_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic             skip_q, skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pc_load_q, pc_load_d;
  logic [PC_W-1:0]  pc_val_q, pc_val_d;

  logic cmd_ready;
  logic accept;
  logic bp_match;
  logic cpu_en;
  logic load_pc;

  logic op_run, op_halt, op_step;
  logic op_setbp, op_clrbp, op_loadpc;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Handshake, breakpoint compare and zero-latency commit enable
  always_comb begin
    cmd_ready = SYS_reset & (state_q != S_STEP);
    accept    = cmd.CMD_valid & cmd_ready;
    bp_match  = bp_valid_q & (CPU_pc == bp_addr_q) & ~skip_q;
    cpu_en    = SYS_reset &
                (((state_q == S_RUN) & ~bp_match) |
                 (state_q == S_STEP));
  end

  // One-hot command decode of an accepted command
  always_comb begin
    op_run    = 1'b0;
    op_halt   = 1'b0;
    op_step   = 1'b0;
    op_setbp  = 1'b0;
    op_clrbp  = 1'b0;
    op_loadpc = 1'b0;
    if (accept) begin
      unique case (1'b1)
        (cmd.CMD_op == OP_RUN):    op_run    = 1'b1;
        (cmd.CMD_op == OP_HALT):   op_halt   = 1'b1;
        (cmd.CMD_op == OP_STEP):   op_step   = 1'b1;
        (cmd.CMD_op == OP_SETBP):  op_setbp  = 1'b1;
        (cmd.CMD_op == OP_CLRBP):  op_clrbp  = 1'b1;
        (cmd.CMD_op == OP_LOADPC): op_loadpc = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state, breakpoint, flag and counter logic
  always_comb begin
    state_d    = state_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
    exc_d      = exc_q;
    cycles_d   = cycles_q;
    retired_d  = retired_q;
    pc_load_d  = 1'b0;
    pc_val_d   = pc_val_q;
    load_pc    = 1'b0;

    if (cpu_en) begin
      cycles_d = sat_inc(cycles_q);
      skip_d   = 1'b0;
      if (!CPU_exception) begin
        retired_d = sat_inc(retired_q);
      end
    end

    if (op_setbp) begin
      bp_valid_d = 1'b1;
      bp_addr_d  = cmd.CMD_arg;
    end else if (op_clrbp) begin
      bp_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (op_run) begin
          state_d  = S_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (op_step) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end else if (op_loadpc) begin
          load_pc = 1'b1;
        end
      end
      S_RUN: begin
        if (cpu_en && CPU_exception) begin
          state_d = S_EXC;
          exc_d   = 1'b1;
        end else if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (op_halt) begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        if (CPU_exception) begin
          state_d = S_EXC;
          exc_d   = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXC: begin
        if (op_loadpc) begin
          state_d = S_HALT;
          exc_d   = 1'b0;
          load_pc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_pc) begin
      pc_load_d = 1'b1;
      pc_val_d  = cmd.CMD_arg;
      cycles_d  = '0;
      retired_d = '0;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q    <= S_IDLE;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
      exc_q      <= 1'b0;
      cycles_q   <= '0;
      retired_q  <= '0;
      pc_load_q  <= 1'b0;
      pc_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      exc_q      <= exc_d;
      cycles_q   <= cycles_d;
      retired_q  <= retired_d;
      pc_load_q  <= pc_load_d;
      pc_val_q   <= pc_val_d;
    end
  end

  assign cmd.CMD_ready  = cmd_ready;
  assign CPU_en         = cpu_en;
  assign CPU_pc_load    = pc_load_q;
  assign CPU_pc_val     = pc_val_q;
  assign CTRL_state     = state_q;
  assign CTRL_bp_hit    = bp_hit_q;
  assign CTRL_exc       = exc_q;
  assign CTRL_cycles    = cycles_q;
  assign CTRL_retired   = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random commands,
// scoreboarded against a behavioural model of the run controller.
module tb_cpu_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int IDLE = 0, RUN = 1, STEP = 2, HALT = 3, EXC = 4;
  localparam logic [2:0] NOP = 3'd0, C_RUN = 3'd1, C_HALT = 3'd2;
  localparam logic [2:0] C_STEP = 3'd3, C_SETBP = 3'd4;
  localparam logic [2:0] C_CLRBP = 3'd5, C_LOADPC = 3'd6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PC_W-1:0]  cpu_pc_in = '0;
  logic             cpu_exc = 1'b0;
  logic             cpu_en, pc_load;
  logic [PC_W-1:0]  pc_val;
  logic [2:0]       st;
  logic             bp_hit, exc;
  logic [CNT_W-1:0] cyc, ret;

  cpu_run_ctrl_if #(.PC_W(PC_W)) cmd_if();

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .SYS_clk       (clk),
    .SYS_reset     (rst_n),
    .cmd           (cmd_if),
    .CPU_pc        (cpu_pc_in),
    .CPU_exception (cpu_exc),
    .CPU_en        (cpu_en),
    .CPU_pc_load   (pc_load),
    .CPU_pc_val    (pc_val),
    .CTRL_state    (st),
    .CTRL_bp_hit   (bp_hit),
    .CTRL_exc      (exc),
    .CTRL_cycles   (cyc),
    .CTRL_retired  (ret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic             rdy;
    logic [2:0]       st;
    logic             bp_hit;
    logic             exc;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ret;
    logic             pl;
    logic [PC_W-1:0]  pv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int              m_st = IDLE;
  bit              m_bpv, m_skip, m_bph, m_exc, m_pl;
  logic [PC_W-1:0] m_bpa = '0;
  logic [PC_W-1:0] m_pv = '0;
  int              m_cyc, m_ret;
  logic [PC_W-1:0] pc = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_match();
    return m_bpv && (pc == m_bpa) && !m_skip;
  endfunction

  function automatic bit m_en();
    return (m_st == RUN && !m_match()) || (m_st == STEP);
  endfunction

  function automatic int sat1(input int x);
    return (x + 1 > CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_bpv = 0; m_bpa = '0; m_skip = 0;
    m_bph = 0; m_exc = 0; m_cyc = 0; m_ret = 0;
    m_pl = 0; m_pv = '0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] op,
                            input logic [PC_W-1:0] arg, input bit ex);
    bit en, match, acc, load;
    logic [PC_W-1:0] npc;
    en    = m_en();
    match = m_match();
    acc   = v && (m_st != STEP);
    load  = 0;
    npc   = m_pl ? m_pv : (en ? pc + 32'd4 : pc);
    if (en) begin
      m_cyc  = sat1(m_cyc);
      if (!ex) m_ret = sat1(m_ret);
      m_skip = 0;
    end
    if (acc && op == C_SETBP) begin m_bpv = 1; m_bpa = arg; end
    if (acc && op == C_CLRBP) m_bpv = 0;
    case (m_st)
      IDLE, HALT: begin
        if (acc && op == C_RUN) begin
          m_st = RUN; m_skip = 1; m_bph = 0;
        end else if (acc && op == C_STEP) begin
          m_st = STEP; m_bph = 0;
        end else if (acc && op == C_LOADPC) load = 1;
      end
      RUN: begin
        if (en && ex) begin m_st = EXC; m_exc = 1; end
        else if (match) begin m_st = HALT; m_bph = 1; end
        else if (acc && op == C_HALT) m_st = HALT;
      end
      STEP: begin
        if (ex) begin m_st = EXC; m_exc = 1; end
        else m_st = HALT;
      end
      EXC: begin
        if (acc && op == C_LOADPC) begin
          m_st = HALT; m_exc = 0; load = 1;
        end
      end
      default: m_st = IDLE;
    endcase
    m_pl = load;
    if (load) begin m_pv = arg; m_cyc = 0; m_ret = 0; end
    pc = npc;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show
  task automatic cycle(input bit v, input logic [2:0] op,
                       input logic [PC_W-1:0] arg, input bit ex);
    exp_t e;
    @(negedge clk);
    cmd_if.CMD_valid = v;
    cmd_if.CMD_op    = op;
    cmd_if.CMD_arg   = arg;
    cpu_exc          = ex;
    cpu_pc_in        = pc;
    e.en     = m_en();
    e.rdy    = (m_st != STEP);
    e.st     = 3'(m_st);
    e.bp_hit = m_bph;
    e.exc    = m_exc;
    e.cyc    = CNT_W'(m_cyc);
    e.ret    = CNT_W'(m_ret);
    e.pl     = m_pl;
    e.pv     = m_pv;
    sb.push_back(e);
    model_step(v, op, arg, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, NOP, '0, 0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    cmd_if.CMD_valid = 0;
    cpu_exc   = 0;
    cpu_pc_in = pc;
    #1 chk("pre_reset_en", cpu_en, m_en());
    #2 rst_n = 0;
    #1;
    chk("rst_en", cpu_en, 0);
    chk("rst_ready", cmd_if.CMD_ready, 0);
    chk("rst_state", st, 0);
    chk("rst_cycles", cyc, 0);
    chk("rst_retired", ret, 0);
    chk("rst_bp_hit", bp_hit, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: compare DUT against the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("cpu_en", cpu_en, mon_e.en);
        chk("cmd_ready", cmd_if.CMD_ready, mon_e.rdy);
        chk("state", st, mon_e.st);
        chk("bp_hit", bp_hit, mon_e.bp_hit);
        chk("exc", exc, mon_e.exc);
        chk("cycles", cyc, mon_e.cyc);
        chk("retired", ret, mon_e.ret);
        chk("pc_load", pc_load, mon_e.pl);
        chk("pc_val", pc_val, mon_e.pv);
      end
    end
  end

  initial begin
    bit found;
    cmd_if.CMD_valid = 0;
    cmd_if.CMD_op    = NOP;
    cmd_if.CMD_arg   = '0;
    model_reset();
    #2;
    chk("init_state", st, 0);
    chk("init_ready", cmd_if.CMD_ready, 0);
    chk("init_en", cpu_en, 0);
    chk("init_pc_load", pc_load, 0);
    chk("init_pc_val", pc_val, 0);
    chk("init_exc", exc, 0);
    chk("init_cycles", cyc, 0);
    chk("init_retired", ret, 0);
    @(negedge clk);
    rst_n = 1;

    // Load start PC, run ten cycles
    cycle(1, C_LOADPC, 32'h40, 0);
    idle(1);
    cycle(1, C_RUN, '0, 0);
    idle(10);
    cycle(1, C_HALT, '0, 0);
    idle(1);

    // Breakpoint stop, then resume past it
    cycle(1, C_SETBP, 32'h4C, 0);
    cycle(1, C_LOADPC, 32'h40, 0);
    idle(1);
    cycle(1, C_RUN, '0, 0);
    idle(6);
    cycle(1, C_RUN, '0, 0);
    idle(3);
    cycle(1, C_HALT, '0, 0);
    idle(1);

    // Single steps, breakpoint on the first stepped PC
    cycle(1, C_SETBP, pc, 0);
    repeat (3) begin
      cycle(1, C_STEP, '0, 0);
      cycle(1, C_RUN, '0, 0);
    end
    idle(1);

    // Exception in RUN, ignored RUN, recovery by LOADPC
    cycle(1, C_CLRBP, '0, 0);
    cycle(1, C_RUN, '0, 0);
    idle(2);
    cycle(0, NOP, '0, 1);
    cycle(1, C_RUN, '0, 0);
    idle(1);
    cycle(1, C_LOADPC, 32'h0, 0);
    idle(2);

    // Exception beats a same-cycle HALT
    cycle(1, C_RUN, '0, 0);
    idle(1);
    cycle(1, C_HALT, '0, 1);
    cycle(1, C_LOADPC, 32'h40, 0);
    idle(1);

    // Breakpoint and HALT in the same cycle, then async reset
    cycle(1, C_SETBP, 32'h48, 0);
    cycle(1, C_RUN, '0, 0);
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_st == RUN && m_match()) begin
        cycle(1, C_HALT, '0, 0);
        found = 1;
        break;
      end
      cycle(0, NOP, '0, 0);
    end
    chk("bp_halt_seen", found, 1);
    idle(1);
    cycle(1, C_RUN, '0, 0);
    idle(2);
    reset_mid();

    // Counter saturation
    cycle(1, C_LOADPC, 32'h100, 0);
    idle(1);
    cycle(1, C_RUN, '0, 0);
    idle(20);
    cycle(1, C_HALT, '0, 0);
    idle(1);

    // Random commands
    repeat (600) begin
      bit v, ex;
      logic [2:0] op;
      logic [PC_W-1:0] arg;
      v   = 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      arg = 32'h40 + 32'(4 * $urandom_range(0, 7));
      ex  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0)
        pc = 32'h40 + 32'(4 * $urandom_range(0, 7));
      cycle(v, op, arg, ex);
    end

    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
